zece_exec_unit: RTL

Operational (datapath) unit directly downstream of the ten-state control automaton. Consumes the automaton's one-hot-ish microoperation strobes t1..t9 and executes them on registers A, B and counter C. Returns condition flags x and y to the automaton, which samples them on its next clock edge. Exposes the final result with a valid flag.

---
 rtl/zece_pkg.sv | 48 ++++
 rtl/zece_down_counter.sv | 43 ++++
 rtl/zece_exec_unit.sv | 166 ++++++++++++++++
 3 files changed

// File: rtl/zece_pkg.sv
// ============================================================================
//  Module      : zece_pkg
//  Description : Shared constants, types and helpers for the zece exec unit.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package zece_pkg;

    localparam int NUM_T = 9;
    localparam int T1 = 1;
    localparam int T2 = 2;
    localparam int T3 = 3;
    localparam int T4 = 4;
    localparam int T5 = 5;
    localparam int T6 = 6;
    localparam int T7 = 7;
    localparam int T8 = 8;
    localparam int T9 = 9;

    localparam int W_DEF        = 8;
    localparam int CNT_W_DEF    = 4;
    localparam int CNT_INIT_DEF = 8;

    localparam int FLAG_X = 0;
    localparam int FLAG_Y = 1;

    typedef enum logic [2:0] {
        A_HOLD     = 3'd0,
        A_CLR      = 3'd1,
        A_LOAD     = 3'd2,
        A_ADD      = 3'd3,
        A_SUB      = 3'd4,
        A_CONFLICT = 3'd5
    } a_op_e;

    // Signed overflow from operand/result sign bits only, so width-agnostic.
    function automatic logic add_ovf(input logic sa, input logic sb, input logic sr);
        return (sa == sb) && (sr != sa);
    endfunction

    function automatic logic sub_ovf(input logic sa, input logic sb, input logic sr);
        return (sa != sb) && (sr != sa);
    endfunction

endpackage

`default_nettype wire

// File: rtl/zece_down_counter.sv
// ============================================================================
//  Module      : zece_down_counter
//  Description : Saturating down counter with load; zero flag feeds the y output.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module zece_down_counter #(
    parameter int CNT_W    = 4,
    parameter int CNT_INIT = 8
) (
    input  logic clk,
    input  logic res,
    input  logic load_i,
    input  logic dec_i,
    output logic zero_o
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = CNT_W'(CNT_INIT);
        end else if (dec_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk or posedge res) begin
        if (res) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero_o = (cnt_q == '0);

endmodule

`default_nettype wire

// File: rtl/zece_exec_unit.sv
// ============================================================================
//  Module      : zece_exec_unit
//  Description : Datapath executing microop strobes t1..t9 on A, B and C.
//                Optional signed-overflow flag enabled by macro OVF_DETECT_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module zece_exec_unit
    import zece_pkg::*;
#(
    parameter int W        = W_DEF,
    parameter int CNT_W    = CNT_W_DEF,
    parameter int CNT_INIT = CNT_INIT_DEF
) (
    input  logic         clk,
    input  logic         res,
    input  logic         t1,
    input  logic         t2,
    input  logic         t3,
    input  logic         t4,
    input  logic         t5,
    input  logic         t6,
    input  logic         t7,
    input  logic         t8,
    input  logic         t9,
    input  logic [W-1:0] a_in,
    input  logic [W-1:0] b_in,
    output logic         x,
    output logic         y,
    output logic [W-1:0] result,
    output logic         result_valid,
    output logic         illegal_op,
    output logic         ovf
);

    logic [NUM_T:1] w_t;
    logic [W-1:0]   a_q, a_d;
    logic [W-1:0]   b_q, b_d;
    logic [W-1:0]   res_q, res_d;
    logic           valid_q, valid_d;
    logic           ill_q, ill_d;
    logic [W-1:0]   w_sum, w_diff;
    logic           w_zero;
    logic [1:0]     w_flags;
    a_op_e          a_op;

    assign w_t    = {t9, t8, t7, t6, t5, t4, t3, t2, t1};
    assign w_sum  = a_q + b_q;
    assign w_diff = a_q - b_q;

    // t1 and t5 together are a conflict: A holds and illegal_op pulses.
    always_comb begin
        a_op = A_HOLD;
        if (w_t[T6]) begin
            a_op = A_CLR;
        end else if (w_t[T7]) begin
            a_op = A_LOAD;
        end else if (w_t[T1] && w_t[T5]) begin
            a_op = A_CONFLICT;
        end else if (w_t[T1]) begin
            a_op = A_ADD;
        end else if (w_t[T5]) begin
            a_op = A_SUB;
        end
    end

    always_comb begin
        a_d = a_q;
        case (a_op)
            A_CLR:   a_d = '0;
            A_LOAD:  a_d = a_in;
            A_ADD:   a_d = w_sum;
            A_SUB:   a_d = w_diff;
            default: a_d = a_q;
        endcase
    end

    always_comb begin
        b_d = b_q;
        if (w_t[T8]) begin
            b_d = b_in;
        end else if (w_t[T4]) begin
            b_d = {b_q[W-2:0], 1'b0};
        end
    end

    always_comb begin
        res_d   = w_t[T3] ? a_q : res_q;
        valid_d = valid_q;
        if (w_t[T3]) begin
            valid_d = 1'b1;
        end else if (w_t[T7]) begin
            valid_d = 1'b0;
        end
        ill_d = (a_op == A_CONFLICT);
    end

    always_ff @(posedge clk or posedge res) begin
        if (res) begin
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            valid_q <= 1'b0;
            ill_q   <= 1'b0;
        end else begin
            a_q     <= a_d;
            b_q     <= b_d;
            res_q   <= res_d;
            valid_q <= valid_d;
            ill_q   <= ill_d;
        end
    end

`ifdef OVF_DETECT_EN
    logic ovf_q, ovf_d;
    logic w_ovf_set;

    assign w_ovf_set = ((a_op == A_ADD) && add_ovf(a_q[W-1], b_q[W-1], w_sum[W-1])) ||
                       ((a_op == A_SUB) && sub_ovf(a_q[W-1], b_q[W-1], w_diff[W-1]));

    always_comb begin
        ovf_d = ovf_q;
        if (w_ovf_set) begin
            ovf_d = 1'b1;
        end else if (w_t[T7]) begin
            ovf_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge res) begin
        if (res) begin
            ovf_q <= 1'b0;
        end else begin
            ovf_q <= ovf_d;
        end
    end

    assign ovf = ovf_q;
`else
    assign ovf = 1'b0;
`endif

    zece_down_counter #(
        .CNT_W    (CNT_W),
        .CNT_INIT (CNT_INIT)
    ) u_counter (
        .clk    (clk),
        .res    (res),
        .load_i (w_t[T9]),
        .dec_i  (w_t[T2]),
        .zero_o (w_zero)
    );

    assign w_flags[FLAG_X] = a_q[W-1];
    assign w_flags[FLAG_Y] = w_zero;

    assign x            = w_flags[FLAG_X];
    assign y            = w_flags[FLAG_Y];
    assign result       = res_q;
    assign result_valid = valid_q;
    assign illegal_op   = ill_q;

endmodule

`default_nettype wire
